// File: rtl/traffic_sequencer.sv
// Timed Moore sequencer for a main/side/pedestrian junction.
// A prescaler produces timing ticks and each state is held for a whole number of ticks.
module traffic_sequencer #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned MAIN_MIN = 10,
    parameter int unsigned YEL_T    = 3,
    parameter int unsigned ALLRED_T = 1,
    parameter int unsigned SIDE_T   = 8,
    parameter int unsigned WALK_T   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_car,
    input  logic       walk_btn,
    output logic [6:0] light_signals,
    output logic [2:0] state_o,
    output logic       tick_o
);

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        ALL_RED_A   = 3'd2,
        SIDE_GREEN  = 3'd3,
        SIDE_YELLOW = 3'd4,
        WALK        = 3'd5,
        ALL_RED_B   = 3'd6
    } state_t;

    localparam int unsigned   PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] prescaler;
    logic          tick;
    logic [1:0]    side_sync;
    logic [1:0]    walk_sync;
    logic          side_s;
    logic          walk_s;
    logic          side_pending;
    logic          walk_pending;
    state_t        state;
    state_t        next_state;
    logic [7:0]    timer;
    logic          at_last;
    logic          step;
    logic          enter_side;
    logic          enter_walk;

    // Last timer value of each state; the timer counts 0..D-1 ticks.
    function automatic logic [7:0] dur_m1(input state_t s);
        case (s)
            MAIN_GREEN:              dur_m1 = 8'(MAIN_MIN - 1);
            MAIN_YELLOW, SIDE_YELLOW: dur_m1 = 8'(YEL_T - 1);
            SIDE_GREEN:              dur_m1 = 8'(SIDE_T - 1);
            WALK:                    dur_m1 = 8'(WALK_T - 1);
            default:                 dur_m1 = 8'(ALLRED_T - 1);
        endcase
    endfunction

    // Lamp pattern {Rm,Ym,Gm,Rs,Ys,Gs,W}; anything unknown shows all-red.
    function automatic logic [6:0] lamps(input state_t s);
        case (s)
            MAIN_GREEN:  lamps = 7'h18;
            MAIN_YELLOW: lamps = 7'h28;
            SIDE_GREEN:  lamps = 7'h42;
            SIDE_YELLOW: lamps = 7'h44;
            WALK:        lamps = 7'h49;
            default:     lamps = 7'h48;
        endcase
    endfunction

    assign tick    = (prescaler == PRE_LAST);
    assign tick_o  = tick;
    assign side_s  = side_sync[1];
    assign walk_s  = walk_sync[1];
    assign at_last = (timer == dur_m1(state));
    assign step    = tick && at_last;
    assign state_o = state;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler <= '0;
            side_sync <= '0;
            walk_sync <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
            side_sync <= {side_sync[0], side_car};
            walk_sync <= {walk_sync[0], walk_btn};
        end
    end

    // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_state = state;
        case (state)
            MAIN_GREEN:  if (step && (side_pending || walk_pending)) next_state = MAIN_YELLOW;
            MAIN_YELLOW: if (step) next_state = ALL_RED_A;
            ALL_RED_A:   if (step) next_state = walk_pending ? WALK : SIDE_GREEN;
            SIDE_GREEN:  if (step) next_state = SIDE_YELLOW;
            SIDE_YELLOW: if (step) next_state = ALL_RED_B;
            WALK:        if (step) next_state = ALL_RED_B;
            ALL_RED_B:   if (step) next_state = MAIN_GREEN;
            default:     next_state = ALL_RED_B;
        endcase
    end

    assign enter_side = (next_state == SIDE_GREEN) && (state != SIDE_GREEN);
    assign enter_walk = (next_state == WALK) && (state != WALK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ALL_RED_B;
            timer         <= 8'd0;
            light_signals <= 7'h48;
            side_pending  <= 1'b0;
            walk_pending  <= 1'b0;
        end else begin
            state         <= next_state;
            light_signals <= lamps(next_state);
            // MAIN_GREEN idling at its minimum keeps the timer saturated at the last value.
            if (next_state != state) begin
                timer <= 8'd0;
            end else if (tick && !at_last) begin
                timer <= timer + 8'd1;
            end
            if (enter_side) begin
                side_pending <= 1'b0;
            end else if (side_s && state != SIDE_GREEN && state != SIDE_YELLOW) begin
                side_pending <= 1'b1;
            end
            if (enter_walk) begin
                walk_pending <= 1'b0;
            end else if (walk_s && state != WALK) begin
                walk_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_traffic_sequencer.sv
// Scoreboard bench: stimulus queues expected lamp segments (value, length in clk);
// a negedge monitor closes each segment on a lamp change and compares it.
module tb_traffic_sequencer;

    typedef struct {
        logic [6:0] val;
        int         len;   // 0: length not checked (segment cut short by reset)
    } seg_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       side_car = 1'b0;
    logic       walk_btn = 1'b0;
    logic [6:0] light_signals;
    logic [2:0] state_o;
    logic       tick_o;

    seg_t       exp_q[$];
    int         tests_run = 0;
    int         tests_failed = 0;
    int         inv_viol = 0;
    int         seg_n = 0;
    int         run = 0;
    int         now_e = 0;
    logic [6:0] cur = 7'h00;

    traffic_sequencer #(
        .TICK_DIV(4), .MAIN_MIN(3), .YEL_T(2), .ALLRED_T(1), .SIDE_T(3), .WALK_T(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .side_car(side_car), .walk_btn(walk_btn),
        .light_signals(light_signals), .state_o(state_o), .tick_o(tick_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic push(input logic [6:0] v, input int l);
        seg_t s;
        s.val = v;
        s.len = l;
        exp_q.push_back(s);
    endtask

    task automatic emit(input logic [6:0] v, input int l);
        seg_t e;
        seg_n++;
        if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL seg%0d_unexpected: got 0x%0h for %0d clk, expected no further segment", seg_n, v, l);
        end else begin
            e = exp_q.pop_front();
            check($sformatf("seg%0d_value", seg_n), 32'(v), 32'(e.val));
            if (e.len != 0) check($sformatf("seg%0d_length", seg_n), l, e.len);
        end
    endtask

    // Monitor: segment tracking plus the lamp safety invariant.
    always @(negedge clk) begin
        if (!rst_n) begin
            if (run > 0) emit(cur, run);
            run = 0;
        end else begin
            if (!$onehot(light_signals[6:4]) || !$onehot(light_signals[3:1]) ||
                ((light_signals[5] | light_signals[4]) && (|light_signals[2:0]))) begin
                inv_viol++;
                $display("FAIL invariant: lamps 0x%0h violate exclusivity", light_signals);
            end
            if (run == 0) begin
                cur = light_signals;
                run = 1;
            end else if (light_signals === cur) begin
                run++;
            end else begin
                emit(cur, run);
                cur = light_signals;
                run = 1;
            end
        end
    end

    // Advance to 2 time units after posedge number k since the last reset release.
    task automatic at_edge(input int k);
        repeat (k - now_e) @(posedge clk);
        #2;
        now_e = k;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        now_e = 0;
    endtask

    task automatic check_ticks(input string tag);
        for (int k = 1; k <= 8; k++) begin
            at_edge(k);
            check($sformatf("%s_tick_e%0d", tag, k), 32'(tick_o), 32'((k % 4) == 3));
            check($sformatf("%s_state_e%0d", tag, k), 32'(state_o), (k >= 4) ? 32'd0 : 32'd6);
        end
    endtask

    // Side-only or walk-plus-side cycle tails, as hand-computed lamp segments.
    task automatic push_side_cycle;
        push(7'h28, 8); push(7'h48, 4); push(7'h42, 12); push(7'h44, 8); push(7'h48, 4);
    endtask

    task automatic push_both_cycle;
        push(7'h48, 4); push(7'h18, 12); push(7'h28, 8); push(7'h48, 4); push(7'h49, 8);
        push(7'h48, 4); push(7'h18, 12);
        push_side_cycle();
        push(7'h18, 0);
    endtask

    initial begin
        // Reset state while rst_n is held low from time 0.
        #12;
        check("rst_lamps", 32'(light_signals), 32'h48);
        check("rst_state", 32'(state_o), 32'd6);
        check("rst_tick", 32'(tick_o), 32'd0);

        // 1: idle after reset.
        push(7'h48, 4); push(7'h18, 0);
        do_reset();
        check_ticks("s1");
        at_edge(204);
        check("s1_idle_lamps", 32'(light_signals), 32'h18);

        // 2: short side_car pulse during the first MAIN_GREEN tick.
        push(7'h48, 4); push(7'h18, 12); push_side_cycle(); push(7'h18, 0);
        do_reset();
        at_edge(9);  side_car = 1'b1;
        at_edge(12); side_car = 1'b0;
        at_edge(100);

        // 3: walk request after MAIN_GREEN has idled.
        push(7'h48, 4); push(7'h18, 44); push(7'h28, 8); push(7'h48, 4); push(7'h49, 8);
        push(7'h48, 4); push(7'h18, 0);
        do_reset();
        at_edge(44); walk_btn = 1'b1;
        at_edge(46); walk_btn = 1'b0;
        at_edge(110);
        check("s3_walk_pending", 32'(dut.walk_pending), 32'd0);

        // 4: both requests together; walk first, side after a full minimum.
        push_both_cycle();
        do_reset();
        at_edge(5); side_car = 1'b1; walk_btn = 1'b1;
        at_edge(7); side_car = 1'b0; walk_btn = 1'b0;
        at_edge(130);

        // 5: presses during WALK and SIDE_GREEN are not latched.
        push_both_cycle();
        do_reset();
        at_edge(5);  side_car = 1'b1; walk_btn = 1'b1;
        at_edge(7);  side_car = 1'b0; walk_btn = 1'b0;
        at_edge(29); walk_btn = 1'b1;
        at_edge(31); walk_btn = 1'b0;
        at_edge(66); side_car = 1'b1;
        at_edge(68); side_car = 1'b0;
        at_edge(170);
        check("s5_side_pending", 32'(dut.side_pending), 32'd0);
        check("s5_walk_pending", 32'(dut.walk_pending), 32'd0);

        // 6: one-clk reset in the middle of SIDE_GREEN, then a clean restart.
        push(7'h48, 4); push(7'h18, 12); push(7'h28, 8); push(7'h48, 4); push(7'h42, 0);
        push(7'h48, 4); push(7'h18, 0);
        do_reset();
        at_edge(9);  side_car = 1'b1;
        at_edge(12); side_car = 1'b0;
        at_edge(32);
        check("s6_pre_rst_lamps", 32'(light_signals), 32'h42);
        rst_n = 1'b0;
        #1;
        check("s6_async_lamps", 32'(light_signals), 32'h48);
        check("s6_async_state", 32'(state_o), 32'd6);
        at_edge(33);
        rst_n = 1'b1;
        now_e = 0;
        check_ticks("s6");
        at_edge(60);
        check("s6_idle_lamps", 32'(light_signals), 32'h18);

        // Flush the final idle segment and confirm every expectation was consumed.
        do_reset();
        at_edge(2);
        check("queue_drained", exp_q.size(), 32'd0);
        check("invariant_violations", inv_viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
